// File: rtl/filling_direction_counter_if.sv
// Fill-side bundle between the scoring datapath, the fill counter and the direction RAM
// write port. The master drives fill control and symbols; the slave is the counter.
interface filling_direction_counter_if #(
  parameter int BitAddr = 8
);
  logic               en_fill;
  logic               score_valid;
  logic [2:0]         symbol;
  logic               ready;
  logic [BitAddr:0]   i_f;
  logic [BitAddr:0]   j_f;
  logic               we;
  logic [BitAddr:0]   addr_i;
  logic [BitAddr:0]   addr_j;
  logic [2:0]         data_out;
  logic               end_f;
  logic               err;

  modport master (
    output en_fill, score_valid, symbol,
    input  ready, i_f, j_f, we, addr_i, addr_j, data_out, end_f, err
  );

  modport slave (
    input  en_fill, score_valid, symbol,
    output ready, i_f, j_f, we, addr_i, addr_j, data_out, end_f, err
  );
endinterface

// File: rtl/filling_direction_counter.sv
// Walks the N x N score matrix row-major during fill, writing one direction symbol per
// cell into the direction RAM and flagging completion for the traceback phase.
//
// state    | meaning
// IDLE     | fill disabled, counters parked at (1,1)
// WAIT_SYM | ready high, waiting for a symbol for cell (i_f, j_f)
// WRITE    | one-cycle RAM write of the latched symbol, counters advance on exit
// DONE     | last cell stored, end_f held until en_fill drops
module filling_direction_counter #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
) (
  input logic clk,
  input logic rst,
  filling_direction_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SYM = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [2:0]       SYM_DIAG = 3'b001;
  localparam logic [2:0]       SYM_UP   = 3'b010;
  localparam logic [2:0]       SYM_LEFT = 3'b100;
  localparam logic [BitAddr:0] ONE      = {{BitAddr{1'b0}}, 1'b1};
  localparam logic [BitAddr:0] NMAX     = N[BitAddr:0];

  state_e           state_q, state_d;
  logic [BitAddr:0] i_q, i_d;
  logic [BitAddr:0] j_q, j_d;
  logic [BitAddr:0] addr_i_q, addr_i_d;
  logic [BitAddr:0] addr_j_q, addr_j_d;
  logic [2:0]       data_q, data_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             we_q, we_d;
  logic             end_q, end_d;
  logic             sym_legal;

  assign sym_legal = (bus.symbol == SYM_DIAG) || (bus.symbol == SYM_UP) ||
                     (bus.symbol == SYM_LEFT);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    addr_i_d = addr_i_q;
    addr_j_d = addr_j_q;
    data_d   = data_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        i_d = ONE;
        j_d = ONE;
        if (bus.en_fill) begin
          state_d = WAIT_SYM;
          err_d   = 1'b0;
        end
      end
      WAIT_SYM: begin
        // abort wins over a handshake arriving in the same cycle
        if (!bus.en_fill) begin
          state_d = IDLE;
          i_d     = ONE;
          j_d     = ONE;
        end else if (bus.score_valid) begin
          state_d  = WRITE;
          addr_i_d = i_q - ONE;
          addr_j_d = j_q - ONE;
          data_d   = sym_legal ? bus.symbol : 3'b000;
          if (!sym_legal) err_d = 1'b1;
        end
      end
      WRITE: begin
        if ((i_q == NMAX) && (j_q == NMAX)) begin
          state_d = DONE;
        end else if (!bus.en_fill) begin
          state_d = IDLE;
          i_d     = ONE;
          j_d     = ONE;
        end else begin
          state_d = WAIT_SYM;
          if (j_q == NMAX) begin
            j_d = ONE;
            i_d = i_q + ONE;
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
      DONE: begin
        if (!bus.en_fill) begin
          state_d = IDLE;
          i_d     = ONE;
          j_d     = ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // flag outputs are registered from the next state so they align with state_q
  assign ready_d = (state_d == WAIT_SYM);
  assign we_d    = (state_d == WRITE);
  assign end_d   = (state_d == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      i_q      <= ONE;
      j_q      <= ONE;
      addr_i_q <= '0;
      addr_j_q <= '0;
      data_q   <= 3'b000;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      addr_i_q <= addr_i_d;
      addr_j_q <= addr_j_d;
      data_q   <= data_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      end_q    <= end_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.we       = we_q;
  assign bus.end_f    = end_q;
  assign bus.err      = err_q;
  assign bus.i_f      = i_q;
  assign bus.j_f      = j_q;
  assign bus.addr_i   = addr_i_q;
  assign bus.addr_j   = addr_j_q;
  assign bus.data_out = data_q;

endmodule
